// File: rtl/light_pkg.sv
// Shared types and defaults for the light output multiplexer sequencer.
package light_pkg;

  typedef enum logic [1:0] {
    ST_WHITE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHOW  = 2'd2
  } light_state_e;

  localparam int DEF_ADDR_W      = 3;
  localparam int DEF_NUM_COLOURS = 8;
  localparam int DEF_STEP_TICKS  = 4;
  localparam int DEF_ROM_LAT     = 1;

  typedef logic [23:0] colour_t;
  localparam colour_t WHITE_RGB = 24'hFFFFFF;

endpackage

// File: rtl/light_mux_controller_button_edge_detect.sv
// Single-register rising-edge detector for the synchronous button level.
module button_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic rise
);

  logic button_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) button_q <= 1'b0;
    else     button_q <= button;
  end

  assign rise = button & ~button_q;

endmodule

// File: rtl/light_mux_controller.sv
// Sequencer for the rgb/white light multiplexer: drives sel and the colour-ROM address.
// Optional macro LIGHT_SKIP_RESERVED_EN skips reserved addresses 0 and NUM_COLOURS-1.
module light_mux_controller
  import light_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_COLOURS = DEF_NUM_COLOURS,
  parameter int STEP_TICKS  = DEF_STEP_TICKS,
  parameter int ROM_LAT     = DEF_ROM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              button,
  input  logic              auto_mode,
  output logic [ADDR_W-1:0] colour_addr,
  output logic              sel,
  output logic              busy
);

  localparam logic [1:0] S_WHITE = 2'(ST_WHITE);
  localparam logic [1:0] S_WAIT  = 2'(ST_WAIT);
  localparam logic [1:0] S_SHOW  = 2'(ST_SHOW);

  localparam int LAT_W = $clog2(ROM_LAT + 1);
  localparam int TMR_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

`ifdef LIGHT_SKIP_RESERVED_EN
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NUM_COLOURS - 2);
`else
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NUM_COLOURS - 1);
`endif

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_LAST) ? ADDR_FIRST : a + ADDR_W'(1);
  endfunction

  logic [1:0]       state;
  logic [LAT_W-1:0] wait_cnt;
  logic [LAT_W-1:0] busy_cnt;
  logic [TMR_W-1:0] step_tmr;
  logic             auto_q;
  logic             btn_rise;
  logic             mode_chg;
  logic             tmr_wrap;
  logic             step;

  button_edge_detect u_btn (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .rise   (btn_rise)
  );

  assign mode_chg = auto_mode ^ auto_q;
  assign tmr_wrap = (step_tmr == TMR_W'(STEP_TICKS - 1));

  // A mode change restarts the timer, so a wrap seen in that cycle belongs to the old count.
  always_comb begin
    step = 1'b0;
    if (state == S_SHOW && enable)
      step = auto_mode ? (tmr_wrap && !mode_chg) : btn_rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_WHITE;
      colour_addr <= ADDR_FIRST;
      wait_cnt    <= '0;
      busy_cnt    <= '0;
      step_tmr    <= '0;
      auto_q      <= 1'b0;
    end else begin
      auto_q <= auto_mode;
      case (state)
        S_WHITE: begin
          if (enable) begin
            state    <= S_WAIT;
            wait_cnt <= LAT_W'(ROM_LAT - 1);
          end
        end
        S_WAIT: begin
          if (!enable) begin
            state    <= S_WHITE;
            wait_cnt <= '0;
          end else if (wait_cnt == '0) begin
            state <= S_SHOW;
          end else begin
            wait_cnt <= wait_cnt - LAT_W'(1);
          end
        end
        S_SHOW: begin
          if (!enable) begin
            state    <= S_WHITE;
            step_tmr <= '0;
            busy_cnt <= '0;
          end else begin
            step_tmr <= (mode_chg || tmr_wrap) ? '0 : step_tmr + TMR_W'(1);
            // sel stays high across a step; busy alone flags the ROM settling.
            if (step) begin
              colour_addr <= next_addr(colour_addr);
              busy_cnt    <= LAT_W'(ROM_LAT);
            end else if (busy_cnt != '0) begin
              busy_cnt <= busy_cnt - LAT_W'(1);
            end
          end
        end
        default: state <= S_WHITE;
      endcase
    end
  end

  assign sel  = (state == S_SHOW);
  assign busy = (state == S_WAIT) || (busy_cnt != '0);

endmodule
